// File: rtl/mem_bus_master.sv
// Load/store initiator for the data-RAM bus: one access at a time, lane steering and load extension.
// Latency: done 2+ cycles after an aligned request, 1 cycle after a misaligned one; stall_o holds the pipe meanwhile.
`timescale 1ns/1ps
module mem_bus_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    output logic        ram_ce_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_ready_i
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        we_q, signed_q, align_q, berr_q;
    logic [1:0]  size_q, lo_q;
    logic [31:0] addr_q, wdata_q, rword_q;
    logic [3:0]  sel_q;

    logic        is_byte, is_half, misalign, timeout_hit;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d, load_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign is_byte     = (req_size_i == 2'b00);
    assign is_half     = (req_size_i == 2'b01);
    assign misalign    = (is_half & req_addr_i[0]) | (!is_byte && !is_half && (req_addr_i[1:0] != 2'b00));
    assign timeout_hit = ((cnt_q + 8'd1) == TO);

    // Big-endian lanes: byte address 0 lives in the most significant lane.
    always_comb begin
        sel_d   = 4'b1111;
        wdata_d = req_wdata_i;
        if (is_byte) begin
            sel_d   = 4'b1000 >> req_addr_i[1:0];
            wdata_d = {4{req_wdata_i[7:0]}};
        end else if (is_half) begin
            sel_d   = req_addr_i[1] ? 4'b0011 : 4'b1100;
            wdata_d = {2{req_wdata_i[15:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = misalign ? DONE : BUSY;
            BUSY:    if (ram_ready_i || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= 8'd0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            align_q  <= 1'b0;
            berr_q   <= 1'b0;
            size_q   <= 2'b00;
            lo_q     <= 2'b00;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rword_q  <= 32'd0;
            sel_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: if (req_i) begin
                    align_q <= misalign;
                    berr_q  <= 1'b0;
                    if (!misalign) begin
                        cnt_q    <= 8'd0;
                        we_q     <= req_we_i;
                        signed_q <= req_signed_i;
                        size_q   <= req_size_i;
                        lo_q     <= req_addr_i[1:0];
                        addr_q   <= {req_addr_i[31:2], 2'b00};
                        wdata_q  <= wdata_d;
                        sel_q    <= sel_d;
                    end
                end
                // Ready wins over a timeout landing in the same cycle.
                BUSY: if (ram_ready_i) begin
                    rword_q <= ram_data_i;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                    if (timeout_hit) berr_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (lo_q)
            2'b00:   byte_lane = rword_q[31:24];
            2'b01:   byte_lane = rword_q[23:16];
            2'b10:   byte_lane = rword_q[15:8];
            default: byte_lane = rword_q[7:0];
        endcase
        half_lane = lo_q[1] ? rword_q[15:0] : rword_q[31:16];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_ext = rword_q;
        endcase
    end

    assign stall_o     = ((state_q == IDLE) & req_i) | (state_q == BUSY);
    assign done_o      = (state_q == DONE);
    assign align_err_o = done_o & align_q;
    assign bus_err_o   = done_o & berr_q;
    assign rdata_o     = (done_o && !we_q && !align_q && !berr_q) ? load_ext : 32'd0;
    assign ram_ce_o    = (state_q == BUSY);
    assign ram_we_o    = ram_ce_o & we_q;
    assign ram_addr_o  = addr_q;
    assign ram_sel_o   = sel_q;
    assign ram_data_o  = wdata_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master (TIMEOUT=4): vector table through a scoreboard, plus reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_mem_bus_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, req_we_i, req_signed_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        stall_o, done_o, align_err_o, bus_err_o;
    logic [31:0] rdata_o, ram_addr_o, ram_data_o;
    logic        ram_we_o, ram_ce_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_i;
    logic        ram_ready_i;

    mem_bus_master #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_signed_i(req_signed_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .align_err_o(align_err_o), .bus_err_o(bus_err_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_data_o(ram_data_o), .ram_ce_o(ram_ce_o),
        .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdin;
        int          rdy_cyc;   // cycle in which ready is raised, 0 = never
        logic [3:0]  sel;
        logic [31:0] ram_dat;
        logic [31:0] rdata;
        logic        align;
        logic        berr;
        int          done_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        align;
        logic        berr;
        int          cyc;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdin,
                                input int rdy, input logic [3:0] sel, input logic [31:0] ram_dat,
                                input logic [31:0] rdata, input logic align, input logic berr, input int dc);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.rdin = rdin;
        v.rdy_cyc = rdy; v.sel = sel; v.ram_dat = ram_dat; v.rdata = rdata;
        v.align = align; v.berr = berr; v.done_cyc = dc;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge with the DUT idle; returns at #1 after an edge, idle again.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        bit   seen;
        req_i = 1'b1; req_we_i = v.we; req_size_i = v.size; req_signed_i = v.sgn;
        req_addr_i = v.addr; req_wdata_i = v.wdata; ram_ready_i = 1'b0;
        e.rdata = v.rdata; e.align = v.align; e.berr = v.berr; e.cyc = v.done_cyc;
        sb.push_back(e);
        #1;
        chk($sformatf("v%0d stall_c0", idx), {31'd0, stall_o}, 32'd1);
        chk($sformatf("v%0d ce_c0", idx), {31'd0, ram_ce_o}, 32'd0);
        seen = 1'b0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            tick();
            req_i = 1'b0; req_addr_i = ~v.addr; req_wdata_i = 32'h5A5A_5A5A;
            req_size_i = ~v.size; req_we_i = ~v.we;
            ram_ready_i = (v.rdy_cyc == c);
            ram_data_i = ram_ready_i ? v.rdin : $urandom;
            #1;
            if (done_o) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL v%0d sb_empty: got done with no expected entry", idx);
                end else begin
                    got = sb.pop_front();
                    chk($sformatf("v%0d done_cycle", idx), c, got.cyc);
                    chk($sformatf("v%0d rdata", idx), rdata_o, got.rdata);
                    chk($sformatf("v%0d align_err", idx), {31'd0, align_err_o}, {31'd0, got.align});
                    chk($sformatf("v%0d bus_err", idx), {31'd0, bus_err_o}, {31'd0, got.berr});
                end
                chk($sformatf("v%0d stall_done", idx), {31'd0, stall_o}, 32'd0);
                chk($sformatf("v%0d ce_done", idx), {31'd0, ram_ce_o}, 32'd0);
            end else begin
                chk($sformatf("v%0d ce_busy", idx), {31'd0, ram_ce_o}, {31'd0, !v.align});
                chk($sformatf("v%0d stall_busy", idx), {31'd0, stall_o}, {31'd0, !v.align});
                if (!v.align) begin
                    chk($sformatf("v%0d addr", idx), ram_addr_o, {v.addr[31:2], 2'b00});
                    chk($sformatf("v%0d sel", idx), {28'd0, ram_sel_o}, {28'd0, v.sel});
                    chk($sformatf("v%0d we", idx), {31'd0, ram_we_o}, {31'd0, v.we});
                    chk($sformatf("v%0d wdat", idx), ram_data_o, v.ram_dat);
                end
            end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL v%0d no_done: got no done within 12 cycles expected cycle %0d", idx, v.done_cyc);
            void'(sb.pop_front());
        end
        ram_ready_i = 1'b0;
        tick();
        chk($sformatf("v%0d done_after", idx), {31'd0, done_o}, 32'd0);
        chk($sformatf("v%0d ce_after", idx), {31'd0, ram_ce_o}, 32'd0);
    endtask

    initial begin
        logic [5:0] dpat;
        logic [5:0] spat;
        rst = 1'b0; req_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_signed_i = 1'b0;
        req_addr_i = 32'd0; req_wdata_i = 32'd0; ram_data_i = 32'd0; ram_ready_i = 1'b0;

        tbl[0]  = mk(0, 2'b10, 0, 32'h104, 32'h0,       32'hDEADBEEF, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0, 2);
        tbl[1]  = mk(0, 2'b00, 1, 32'h3,   32'h0,       32'h000000F0, 1, 4'b0001, 32'h0,        32'hFFFFFFF0, 0, 0, 2);
        tbl[2]  = mk(0, 2'b00, 0, 32'h3,   32'h0,       32'h000000F0, 1, 4'b0001, 32'h0,        32'h000000F0, 0, 0, 2);
        tbl[3]  = mk(1, 2'b01, 0, 32'h2,   32'h1234,    32'h0,        3, 4'b0011, 32'h12341234, 32'h0,        0, 0, 4);
        tbl[4]  = mk(0, 2'b10, 0, 32'h6,   32'h0,       32'h0,        1, 4'b1111, 32'h0,        32'h0,        1, 0, 1);
        tbl[5]  = mk(0, 2'b10, 0, 32'h20,  32'h0,       32'h0,        0, 4'b1111, 32'h0,        32'h0,        0, 1, 5);
        tbl[6]  = mk(0, 2'b10, 0, 32'h40,  32'h0,       32'h12345678, 4, 4'b1111, 32'h0,        32'h12345678, 0, 0, 5);
        tbl[7]  = mk(0, 2'b01, 1, 32'h0,   32'h0,       32'h80010000, 2, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0, 3);
        tbl[8]  = mk(1, 2'b00, 0, 32'h1,   32'hAB,      32'h0,        1, 4'b0100, 32'hABABABAB, 32'h0,        0, 0, 2);
        tbl[9]  = mk(0, 2'b01, 0, 32'h1,   32'h0,       32'h0,        1, 4'b1111, 32'h0,        32'h0,        1, 0, 1);
        tbl[10] = mk(0, 2'b01, 0, 32'h2,   32'h0,       32'h1234ABCD, 2, 4'b0011, 32'h0,        32'h0000ABCD, 0, 0, 3);
        tbl[11] = mk(1, 2'b11, 0, 32'h8,   32'hCAFEF00D, 32'h0,       1, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("rst stall", {31'd0, stall_o}, 32'd0);
        chk("rst done", {31'd0, done_o}, 32'd0);
        chk("rst ce", {31'd0, ram_ce_o}, 32'd0);
        chk("rst we", {31'd0, ram_we_o}, 32'd0);
        chk("rst sel", {28'd0, ram_sel_o}, 32'd0);
        chk("rst addr", ram_addr_o, 32'd0);
        chk("rst wdat", ram_data_o, 32'd0);
        chk("rst rdata", rdata_o, 32'd0);
        chk("rst errs", {30'd0, align_err_o, bus_err_o}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // Reset asserted in the middle of a BUSY cycle.
        req_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h80; ram_ready_i = 1'b0;
        tick(); req_i = 1'b0;
        tick();
        chk("mid busy_before_rst", {31'd0, ram_ce_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid rst ce", {31'd0, ram_ce_o}, 32'd0);
        chk("mid rst stall", {31'd0, stall_o}, 32'd0);
        chk("mid rst done", {31'd0, done_o}, 32'd0);
        @(posedge clk); #3 rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("post_rst done c%0d", c), {31'd0, done_o}, 32'd0);
        end
        run_vec(100, tbl[0]);

        // req_i held high with ready always high: DONE-cycle request is ignored.
        req_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_signed_i = 1'b0;
        req_addr_i = 32'h10; ram_ready_i = 1'b1; ram_data_i = 32'h11223344;
        dpat = 6'b010010;
        spat = 6'b101101;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("b2b done c%0d", c), {31'd0, done_o}, {31'd0, dpat[6-c]});
            chk($sformatf("b2b stall c%0d", c), {31'd0, stall_o}, {31'd0, spat[6-c]});
            if (c == 2) chk("b2b rdata", rdata_o, 32'h11223344);
        end
        tick(); req_i = 1'b0;
        tick(); tick();
        ram_ready_i = 1'b0;
        tick();
        chk("b2b idle ce", {31'd0, ram_ce_o}, 32'd0);
        chk("sb drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000ns expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

CPU-side initiator for the data-RAM bus served by `ram_adapter`. It takes one load/store request at a time from the MEM stage and drives `ram_addr_o/ram_we_o/ram_sel_o/ram_data_o/ram_ce_o`. It waits for `ram_ready_i` and returns aligned, sign/zero-extended read data. It holds the pipeline with `stall_o` until the access completes, aborts on misalignment, and times out on a missing ready.

## Interface
- `TIMEOUT`, default 255: maximum number of BUSY cycles without `ram_ready_i` before the access aborts. Range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  MEM stage requests a memory access.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `req_signed_i`  in  1  load sign-extends when 1, zero-extends when 0.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-justified.
- `stall_o`  out  1  pipeline hold request.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  load result; valid when `done_o`=1.
- `align_err_o`  out  1  pulses with `done_o` on a misaligned request.
- `bus_err_o`  out  1  pulses with `done_o` on a timeout.
- `ram_addr_o`  out  32  word address: `{req_addr[31:2],2'b00}`.
- `ram_we_o`  out  1  write enable.
- `ram_sel_o`  out  4  byte-lane enables, big-endian.
- `ram_data_o`  out  32  write data.
- `ram_ce_o`  out  1  bus access strobe.
- `ram_data_i`  in  32  read data from the adapter.
- `ram_ready_i`  in  1  adapter completion flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `req_i`=1 and the request is aligned: latch the request, load the bus registers, clear the timeout counter, go to BUSY.
  - `req_i`=1 and the request is misaligned (half with `addr[0]`=1, or word with `addr[1:0]`≠0): go to DONE with the align flag set. No bus access is made.
  - `ram_ready_i` is ignored in IDLE.
- **BUSY**
  - `ram_ce_o`=1 and the bus registers are held stable.
  - `ram_ready_i`=1: capture `ram_data_i`, go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, go to DONE with the bus-error flag set.
- **DONE**
  - `done_o`=1, `ram_ce_o`=0, next state IDLE unconditionally.
- **Lane mapping (big-endian)**
  - Byte: `addr[1:0]` 00/01/10/11 gives `sel` 1000/0100/0010/0001.
  - Half: `addr[1]` 0/1 gives `sel` 1100/0011.
  - Word: `sel` 1111.
- **Store data replication**
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: as is.
  - `ram_we_o`=1 for the whole BUSY period of a store.
- **Load data**
  - Select the addressed lane from the captured word, then sign- or zero-extend to 32 bits according to `req_signed_i`.
  - `rdata_o`=0 on stores and on errors.
- **stall_o** is combinational: `(IDLE & req_i) | BUSY`. It is low in DONE so the pipeline advances exactly once per access.

## Timing
- **Reset**: all outputs are 0, the state is IDLE and the counter is 0. Reset takes effect immediately, even mid-access; `ram_ce_o` drops asynchronously.
- **Aligned access**
  - `req_i` is seen at cycle 0.
  - `ram_ce_o` is high from cycle 1.
  - If `ram_ready_i` is high in cycle N≥1, `done_o` pulses in cycle N+1.
  - Minimum latency: done 2 cycles after the request.
- **Misaligned access**: `done_o` and `align_err_o` pulse in cycle 1; `ram_ce_o` stays 0.
- **Timeout**: `bus_err_o` pulses with `done_o` in cycle `TIMEOUT`+1 after the request. A `ram_ready_i` arriving in the same cycle the counter hits `TIMEOUT` wins: the access completes normally with no error.
- **Back-to-back**: a new `req_i` is sampled in the IDLE cycle after DONE, giving at most one access per 3 cycles. `req_i` during DONE is ignored.
- **Request capture**: `req_*` is captured only on the IDLE→BUSY transition. Changes to `req_*` during BUSY have no effect.

## Test plan
- **Word load**: `addr` 0x00000104, `ram_ready_i` in cycle 1 with `ram_data_i` 0xDEADBEEF.
  - Expect `ram_addr_o`=0x104, `sel`=1111 and `we`=0 in cycle 1.
  - Expect `done_o` in cycle 2 with `rdata_o`=0xDEADBEEF.
- **Signed byte load**: `addr` 0x3, `ram_data_i` 0x000000F0.
  - Expect `sel`=0001 and `rdata_o`=0xFFFFFFF0.
  - Repeated with `req_signed_i`=0: expect `rdata_o`=0x000000F0.
- **Half store**: `addr` 0x2, `wdata` 0x00001234, ready delayed 3 cycles.
  - Expect `sel`=0011, `ram_data_o`=0x12341234 and `we`=1, held stable for all BUSY cycles.
  - Expect `stall_o` high until DONE.
- **Misaligned word load**: `addr` 0x6.
  - Expect `ram_ce_o` never high.
  - Expect `done_o` and `align_err_o` in cycle 1, with `rdata_o`=0.
- **Timeout**: `TIMEOUT`=4, `ram_ready_i` held at 0.
  - Expect `done_o` and `bus_err_o` in cycle 5, then `ram_ce_o`=0.
  - Repeated with ready arriving exactly at count 4: expect no error.
- **Reset mid-access**: assert `rst` low during BUSY.
  - Expect `ram_ce_o`, `stall_o` and `done_o` at 0 immediately, with no `done_o` after release.
  - Expect the next request after release to complete normally.
